// File: rtl/rsa_encoder_if.sv
// Host-side handshake bundle for rsa_encoder: start/data_in request, busy/done/data_out/err response.
interface rsa_encoder_if;
   logic        start;
   logic [15:0] data_in;
   logic        busy;
   logic        done;
   logic [15:0] data_out;
   logic        err;

   modport master (output start, data_in, input busy, done, data_out, err);
   modport slave  (input start, data_in, output busy, done, data_out, err);
endinterface

// File: rtl/rsa_encoder.sv
// RSA encryption c = m^E mod N, right-to-left square-and-multiply, two cycles per exponent bit.
module rsa_encoder #(
   parameter int unsigned N = 3551,
   parameter int unsigned E = 5
) (
   input logic          clk,
   input logic          res,
   rsa_encoder_if.slave bus
);

   localparam logic [15:0] N_W = 16'(N);
   localparam logic [15:0] E_W = 16'(E);
   localparam logic [31:0] N_L = 32'(N);

   typedef enum logic [1:0] {IDLE, MUL, MOD, FIN} state_t;

   state_t      state;
   logic [15:0] result;
   logic [15:0] base;
   logic [15:0] exp;
   logic [31:0] prod_r;
   logic [31:0] prod_b;
   logic        err_pending;
   logic        busy_r;
   logic        done_r;
   logic [15:0] data_out_r;
   logic        err_r;

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.data_out = data_out_r;
   assign bus.err      = err_r;

   // MUL forms full-width products, MOD reduces them; the loop ends once no exponent bits remain.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state       <= IDLE;
         result      <= '0;
         base        <= '0;
         exp         <= '0;
         prod_r      <= '0;
         prod_b      <= '0;
         err_pending <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         data_out_r  <= '0;
         err_r       <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  busy_r <= 1'b1;
                  err_r  <= 1'b0;
                  if (bus.data_in >= N_W) begin
                     err_pending <= 1'b1;
                     state       <= FIN;
                  end else begin
                     base   <= bus.data_in;
                     result <= 16'd1;
                     exp    <= E_W;
                     state  <= (E_W == 16'd0) ? FIN : MUL;
                  end
               end
            end
            MUL: begin
               prod_r <= exp[0] ? ({16'd0, result} * {16'd0, base}) : {16'd0, result};
               prod_b <= {16'd0, base} * {16'd0, base};
               state  <= MOD;
            end
            MOD: begin
               result <= 16'(prod_r % N_L);
               base   <= 16'(prod_b % N_L);
               exp    <= exp >> 1;
               state  <= (exp[15:1] == 15'd0) ? FIN : MUL;
            end
            FIN: begin
               data_out_r  <= err_pending ? 16'd0 : result;
               err_r       <= err_pending;
               err_pending <= 1'b0;
               done_r      <= 1'b1;
               busy_r      <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
